bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter downstream of the 4x4 shift-add multiplier. It captures the 8-bit product on a start pulse, which is normally the multiplier's done pulse. It runs a shift-add-3 (double dabble) loop over 8 iterations and presents hundreds/tens/units digits to the 7-segment display driver. Start/done handshake matches the multiplier's init/done style.

---
 rtl/bin2bcd_pkg.sv | 25 ++
 rtl/bin2bcd_seq_bcd_add3.sv | 24 ++
 rtl/bin2bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t    : FSM states (IDLE, CORRECT, SHIFT, DONE)
//   W_BIN      : binary input width
//   N_DIG      : number of BCD digits produced
//   ITER       : number of shift iterations (one per binary bit)
//   BLANK_CODE : digit code the display driver shows as all segments off
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

    localparam int W_BIN = 8;
    localparam int N_DIG = 3;
    localparam int ITER  = 8;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORRECT = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble nibble corrector: adds 3 to a BCD nibble
// that is 5 or more, so the following left shift carries into the next
// decimal digit correctly.
// Ports:
//   din  : input  [3:0] BCD nibble before correction
//   dout : output [3:0] corrected nibble
// ---------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A nibble of 5..9 would become 10..18 after doubling; adding 3 first
    // makes that doubling produce the proper decimal carry instead.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Captures the multiplier product on start, runs ITER correct/shift
// iterations and presents hundreds/tens/units to the 7-segment driver.
// Ports:
//   clk      : input        clock, rising edge
//   rst      : input        synchronous active-high reset
//   start    : input        conversion request, only sampled in IDLE
//   bin      : input  [7:0] binary value captured on accepted start
//   busy     : output       high while a conversion is in flight
//   done     : output       one-cycle pulse when the digits update
//   hundreds : output [3:0] BCD digit 2
//   tens     : output [3:0] BCD digit 1
//   units    : output [3:0] BCD digit 0
// Configuration macro:
//   BIN2BCD_BLANK_EN : when defined, leading zeros in hundreds/tens are
//                      replaced by BLANK_CODE when the digits register.
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W_BIN = bin2bcd_pkg::W_BIN,
    parameter int N_DIG = bin2bcd_pkg::N_DIG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_BIN-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       units
);

    localparam int         WORK_W    = 4 * N_DIG + W_BIN;
    localparam logic [3:0] LAST_ITER = 4'(ITER);

    state_t            state;
    logic [3:0]        cnt;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] corrected;
    logic [3:0]        bcd_h;
    logic [3:0]        bcd_t;
    logic [3:0]        bcd_u;
    logic [3:0]        cnt_next;

    // The binary field passes through the correction step untouched; only
    // the BCD nibbles above it are adjusted, each independently with no
    // carry between digits.
    assign corrected[W_BIN-1:0] = work[W_BIN-1:0];

    for (genvar g = 0; g < N_DIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (work[W_BIN + 4*g +: 4]),
            .dout (corrected[W_BIN + 4*g +: 4])
        );
    end

    // Digit views of the BCD field, and the incremented iteration count
    // used to decide when the last shift has happened.
    assign bcd_u    = work[W_BIN +: 4];
    assign bcd_t    = work[W_BIN + 4 +: 4];
    assign bcd_h    = work[W_BIN + 8 +: 4];
    assign cnt_next = cnt + 4'd1;

    // Main FSM. IDLE loads the working register; CORRECT and SHIFT
    // alternate ITER times (correct first, so the final shift leaves a
    // valid BCD field); DONE publishes the digits and pulses done. A start
    // arriving outside IDLE is simply dropped. Reset discards any
    // conversion in flight and zeroes the displayed digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            work     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            units    <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= {{(4*N_DIG){1'b0}}, bin};
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                        state <= CORRECT;
                    end
                end
                CORRECT: begin
                    work  <= corrected;
                    state <= SHIFT;
                end
                SHIFT: begin
                    work <= {work[WORK_W-2:0], 1'b0};
                    cnt  <= cnt_next;
                    if (cnt_next == LAST_ITER) begin
                        state <= DONE;
                    end else begin
                        state <= CORRECT;
                    end
                end
                DONE: begin
`ifdef BIN2BCD_BLANK_EN
                    hundreds <= (bcd_h == 4'd0) ? BLANK_CODE : bcd_h;
                    tens     <= (bcd_h == 4'd0 && bcd_t == 4'd0) ? BLANK_CODE : bcd_t;
`else
                    hundreds <= bcd_h;
                    tens     <= bcd_t;
`endif
                    units <= bcd_u;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq: reset values, a table of fixed
// vectors, hand-written busy/back-to-back/reset sequences and random
// values compared against an arithmetic decimal model.
// Honours BIN2BCD_BLANK_EN in the expected digits.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;

    int check_count = 0;
    int pass_count  = 0;
    int done_seen   = 0;

    typedef struct {
        logic [7:0] bin;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } vec_t;

    vec_t vecs[7];

    bin2bcd_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .hundreds (hundreds),
        .tens     (tens),
        .units    (units)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count done pulses; at the rising edge done still holds the value of
    // the cycle that is ending.
    always @(posedge clk) begin
        if (done) done_seen++;
    end

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input int got, input int exp);
        check_count++;
        if (got == exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Apply the display blanking rule to raw decimal digits.
    function automatic logic [11:0] displayDigits(input int h, input int t, input int u);
        int dh = h;
        int dt = t;
`ifdef BIN2BCD_BLANK_EN
        if (h == 0) dh = 15;
        if (h == 0 && t == 0) dt = 15;
`endif
        return {4'(dh), 4'(dt), 4'(u)};
    endfunction

    // Reference model: plain decimal arithmetic on the input value.
    function automatic logic [11:0] refDigits(input int v);
        return displayDigits(v / 100, (v / 10) % 10, v % 10);
    endfunction

    // Wait (bounded) for done, counting rising edges from the accepting
    // edge; called at a falling edge, returns at the falling edge where
    // done is first seen high.
    task automatic waitDone(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!done && lat < 40);
        if (!done) checkOutput("done_timeout", lat, 17);
    endtask

    task automatic checkDigits(input string name, input logic [11:0] exp);
        checkOutput({name, "_hundreds"}, int'(hundreds), int'(exp[11:8]));
        checkOutput({name, "_tens"},     int'(tens),     int'(exp[7:4]));
        checkOutput({name, "_units"},    int'(units),    int'(exp[3:0]));
    endtask

    // One full conversion with latency, busy and done-width checks.
    task automatic applyStimulus(input string name, input logic [7:0] v, input logic [11:0] exp);
        int lat;
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, "_busy_after_start"}, int'(busy), 1);
        waitDone(lat);
        checkOutput({name, "_latency"}, lat, 17);
        checkOutput({name, "_busy_at_done"}, int'(busy), 0);
        checkDigits(name, exp);
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_done_width"}, int'(done), 0);
    endtask

    initial begin
        int lat;
        int cyc;
        int snap;
        logic [7:0] rv;

        vecs[0] = '{8'd225, 4'd2, 4'd2, 4'd5};
        vecs[1] = '{8'd0,   4'd0, 4'd0, 4'd0};
        vecs[2] = '{8'd255, 4'd2, 4'd5, 4'd5};
        vecs[3] = '{8'd99,  4'd0, 4'd9, 4'd9};
        vecs[4] = '{8'd7,   4'd0, 4'd0, 4'd7};
        vecs[5] = '{8'd100, 4'd1, 4'd0, 4'd0};
        vecs[6] = '{8'd10,  4'd0, 4'd1, 4'd0};

        rst   = 1'b1;
        start = 1'b0;
        bin   = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_hundreds", int'(hundreds), 0);
        checkOutput("reset_tens", int'(tens), 0);
        checkOutput("reset_units", int'(units), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].bin,
                          displayDigits(int'(vecs[i].h), int'(vecs[i].t), int'(vecs[i].u)));
        end

        $display("[TB] start while busy, then start in done cycle");
        snap  = done_seen;
        bin   = 8'd50;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == 4);
            if (cyc == 4) bin = 8'd12;
        end while (!done && cyc < 40);
        start = 1'b0;
        checkOutput("busy_ignore_latency", cyc, 17);
        checkDigits("busy_ignore", displayDigits(0, 5, 0));
        bin   = 8'd12;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_accepted", int'(busy), 1);
        checkOutput("b2b_single_done", done_seen - snap, 1);
        waitDone(lat);
        checkOutput("b2b_latency", lat, 17);
        checkDigits("b2b", displayDigits(0, 1, 2));
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_done_count", done_seen - snap, 2);

        $display("[TB] reset mid-conversion");
        bin   = 8'd200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkDigits("midrst", 12'h000);
        snap = done_seen;
        repeat (25) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_no_done", done_seen - snap, 0);
        applyStimulus("after_rst", 8'd200, refDigits(200));

        $display("[TB] random values");
        for (int i = 0; i < 24; i++) begin
            rv = 8'($urandom_range(0, 255));
            applyStimulus($sformatf("rand%0d_v%0d", i, rv), rv, refDigits(int'(rv)));
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
